// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: sync clear, parallel load, runtime modulus limit, wrap or saturate.
// One-clock latency to cnt/tc/zero, all outputs registered; no backpressure, one action per edge.
module updown_counter_param #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0,
  parameter int UP_RESET = 0
) (
  input  logic             clk_pad,
  input  logic             rst_pad,
  input  logic             clr_pad,
  input  logic             load_pad,
  input  logic             en_pad,
  input  logic             dir_pad,
  input  logic [WIDTH-1:0] din_pad,
  input  logic [WIDTH-1:0] limit_pad,
  output logic [WIDTH-1:0] cnt_pad,
  output logic             tc_pad,
  output logic             zero_pad
);

  localparam logic UP_LVL = (UP_RESET == 0) ? 1'b1 : 1'b0;
  localparam bit   SAT    = (SATURATE != 0);

  logic             count_up;
  logic [WIDTH-1:0] next_cnt;
  logic             next_tc;

  assign count_up = (dir_pad == UP_LVL);

  // Out-of-range values (cnt > limit) count as an up boundary but decrement normally.
  always_comb begin
    next_cnt = cnt_pad;
    next_tc  = 1'b0;
    if (clr_pad) begin
      next_cnt = '0;
    end else if (load_pad) begin
      next_cnt = din_pad;
    end else if (en_pad) begin
      if (count_up) begin
        if (cnt_pad >= limit_pad) begin
          next_tc  = 1'b1;
          next_cnt = SAT ? cnt_pad : '0;
        end else begin
          next_cnt = cnt_pad + 1'b1;
        end
      end else begin
        if (cnt_pad == '0) begin
          next_tc  = 1'b1;
          next_cnt = SAT ? '0 : limit_pad;
        end else begin
          next_cnt = cnt_pad - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      cnt_pad  <= '0;
      tc_pad   <= 1'b0;
      zero_pad <= 1'b1;
    end else begin
      cnt_pad  <= next_cnt;
      tc_pad   <= next_tc;
      zero_pad <= (next_cnt == '0);
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: a wrapping and a saturating instance share all inputs.
module tb_updown_counter_param;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        load;
  logic        en;
  logic        dir;
  logic [15:0] din;
  logic [15:0] limit;
  logic [15:0] w_cnt, s_cnt;
  logic        w_tc, s_tc, w_zero, s_zero;

  int total = 0;
  int bad   = 0;

  updown_counter_param #(.WIDTH(16), .SATURATE(0), .UP_RESET(0)) dut_w (
    .clk_pad(clk), .rst_pad(rst), .clr_pad(clr), .load_pad(load), .en_pad(en),
    .dir_pad(dir), .din_pad(din), .limit_pad(limit),
    .cnt_pad(w_cnt), .tc_pad(w_tc), .zero_pad(w_zero)
  );

  updown_counter_param #(.WIDTH(16), .SATURATE(1), .UP_RESET(0)) dut_s (
    .clk_pad(clk), .rst_pad(rst), .clr_pad(clr), .load_pad(load), .en_pad(en),
    .dir_pad(dir), .din_pad(din), .limit_pad(limit),
    .cnt_pad(s_cnt), .tc_pad(s_tc), .zero_pad(s_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b1;
    din = 16'h0000; limit = 16'hFFFF;
    #3;
    total++;
    if (w_cnt !== 16'h0 || w_tc !== 1'b0 || w_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_w: cnt=%h tc=%b zero=%b want cnt=0000 tc=0 zero=1", w_cnt, w_tc, w_zero);
    end
    total++;
    if (s_cnt !== 16'h0 || s_tc !== 1'b0 || s_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_s: cnt=%h tc=%b zero=%b want cnt=0000 tc=0 zero=1", s_cnt, s_tc, s_zero);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (w_cnt !== 16'h0 || w_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle: cnt=%h zero=%b want cnt=0000 zero=1", w_cnt, w_zero);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; din = 16'h1233; limit = 16'hFFFF;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    total++;
    if (w_cnt !== 16'h1234 || w_zero !== 1'b0) begin
      bad++;
      $display("FAIL count_to_1234: cnt=%h zero=%b want cnt=1234 zero=0", w_cnt, w_zero);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (w_cnt !== 16'h0 || w_tc !== 1'b0 || w_zero !== 1'b1) begin
      bad++;
      $display("FAIL async_rst: cnt=%h tc=%b zero=%b want cnt=0000 tc=0 zero=1", w_cnt, w_tc, w_zero);
    end
    #1 rst = 1'b0;
    tick();
    total++;
    if (w_cnt !== 16'h0001 || w_zero !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_step: cnt=%h zero=%b want cnt=0001 zero=0", w_cnt, w_zero);
    end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [15:0] exp_c [7] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1};
    logic        exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clr = 1'b1; tick(); clr = 1'b0;
    limit = 16'd5; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (w_cnt !== exp_c[i] || w_tc !== exp_t[i] || w_zero !== (exp_c[i] == 16'd0)) begin
        bad++;
        $display("FAIL up_wrap[%0d]: cnt=%h tc=%b zero=%b want cnt=%h tc=%b",
                 i, w_cnt, w_tc, w_zero, exp_c[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [15:0] exp_c [3] = '{16'd0, 16'd5, 16'd4};
    logic        exp_t [3] = '{1'b0, 1'b1, 1'b0};
    limit = 16'd5; load = 1'b1; din = 16'd1; tick(); load = 1'b0;
    dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (w_cnt !== exp_c[i] || w_tc !== exp_t[i] || w_zero !== (exp_c[i] == 16'd0)) begin
        bad++;
        $display("FAIL down_wrap[%0d]: cnt=%h tc=%b zero=%b want cnt=%h tc=%b",
                 i, w_cnt, w_tc, w_zero, exp_c[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [15:0] exp_s [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic        exp_st[3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] exp_w [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    logic        exp_wt[3] = '{1'b0, 1'b1, 1'b0};
    limit = 16'hFFFF; load = 1'b1; din = 16'hFFFE; tick(); load = 1'b0;
    dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (s_cnt !== exp_s[i] || s_tc !== exp_st[i]) begin
        bad++;
        $display("FAIL sat_up[%0d]: cnt=%h tc=%b want cnt=%h tc=%b", i, s_cnt, s_tc, exp_s[i], exp_st[i]);
      end
      total++;
      if (w_cnt !== exp_w[i] || w_tc !== exp_wt[i]) begin
        bad++;
        $display("FAIL wrap_top[%0d]: cnt=%h tc=%b want cnt=%h tc=%b", i, w_cnt, w_tc, exp_w[i], exp_wt[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    limit = 16'hFFFF; dir = 1'b1;
    clr = 1'b1; load = 1'b1; en = 1'b1; din = 16'h00AA;
    tick();
    total++;
    if (w_cnt !== 16'h0 || w_tc !== 1'b0 || w_zero !== 1'b1) begin
      bad++;
      $display("FAIL clr_wins: cnt=%h tc=%b zero=%b want cnt=0000 tc=0 zero=1", w_cnt, w_tc, w_zero);
    end
    clr = 1'b0;
    tick();
    total++;
    if (w_cnt !== 16'h00AA || w_tc !== 1'b0 || w_zero !== 1'b0) begin
      bad++;
      $display("FAIL load_wins: cnt=%h tc=%b zero=%b want cnt=00aa tc=0 zero=0", w_cnt, w_tc, w_zero);
    end
    load = 1'b0; en = 1'b0;
    tick();
    total++;
    if (w_cnt !== 16'h00AA || w_tc !== 1'b0) begin
      bad++;
      $display("FAIL hold: cnt=%h tc=%b want cnt=00aa tc=0", w_cnt, w_tc);
    end
  endtask

  task automatic test_out_of_range();
    limit = 16'h0010; load = 1'b1; din = 16'h0020; tick();
    load = 1'b0; dir = 1'b1; en = 1'b1;
    tick();
    total++;
    if (w_cnt !== 16'h0000 || w_tc !== 1'b1 || w_zero !== 1'b1) begin
      bad++;
      $display("FAIL oor_up_w: cnt=%h tc=%b zero=%b want cnt=0000 tc=1 zero=1", w_cnt, w_tc, w_zero);
    end
    total++;
    if (s_cnt !== 16'h0020 || s_tc !== 1'b1) begin
      bad++;
      $display("FAIL oor_up_s: cnt=%h tc=%b want cnt=0020 tc=1", s_cnt, s_tc);
    end
    en = 1'b0; load = 1'b1; tick();
    load = 1'b0; dir = 1'b0; en = 1'b1;
    tick();
    total++;
    if (w_cnt !== 16'h001F || w_tc !== 1'b0 || s_cnt !== 16'h001F || s_tc !== 1'b0) begin
      bad++;
      $display("FAIL oor_down: w=%h/%b s=%h/%b want 001f/0 for both", w_cnt, w_tc, s_cnt, s_tc);
    end
    en = 1'b0;
  endtask

  task automatic test_limit_zero();
    limit = 16'h0000; clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir = (i < 2) ? 1'b1 : 1'b0;
      tick();
      total++;
      if (w_cnt !== 16'h0 || w_tc !== 1'b1 || s_cnt !== 16'h0 || s_tc !== 1'b1 || w_zero !== 1'b1) begin
        bad++;
        $display("FAIL limit0[%0d]: w=%h/%b s=%h/%b want 0000/1 for both", i, w_cnt, w_tc, s_cnt, s_tc);
      end
    end
    en = 1'b0;
    tick();
    total++;
    if (w_tc !== 1'b0 || s_tc !== 1'b0) begin
      bad++;
      $display("FAIL limit0_idle: w_tc=%b s_tc=%b want 0", w_tc, s_tc);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_out_of_range();
    test_limit_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
